tcdm_banks_pipe_wrap: RTL and testbench
=======================================

// Module: tcdm_banks_pipe_wrap
// PURPOSE
//  Parametrised successor to the cluster's TCDM bank array: NbBanks single-port SRAM banks behind flat per-bank TCDM ports.
//  Adds configurable read latency, an explicit response-valid / response-ID pipeline, and reset-time zero-initialisation (grant withheld while it runs).
//  Sits between the cluster's logarithmic interconnect and the physical banks.
// PARAMETERS
//  BankSize     256  words per bank (power of 2, >=4)
//  NbBanks      16   number of banks
//  DataWidth    32   data width (multiple of 8)
//  AddrWidth    32   request address width (byte address; word index = add[$clog2(BankSize)+1:2])
//  IdWidth      1    request ID width, echoed on response
//  SramLatency  1    macro read latency, 1..2
//  OutReg       0    1: extra response register stage; total latency L = SramLatency+OutReg
//  InitOnReset  1    1: zero every word after reset before granting
// PORTS
//  clk_i        in   1                    clock
//  rst_i        in   1                    synchronous reset, active-high
//  test_mode_i  in   1                    DFT; forwarded to macros, no functional effect
//  req_i        in   NbBanks              request per bank
//  gnt_o        out  NbBanks              grant per bank
//  wen_i        in   NbBanks              1=read, 0=write (TCDM polarity)
//  add_i        in   NbBanks x AddrWidth  byte address
//  data_i       in   NbBanks x DataWidth  write data
//  be_i         in   NbBanks x DataWidth/8 byte enables
//  id_i         in   NbBanks x IdWidth    request ID
//  r_data_o     out  NbBanks x DataWidth  read data
//  r_valid_o    out  NbBanks              response valid (reads and writes)
//  r_id_o       out  NbBanks x IdWidth    response ID
//  init_done_o  out  1                    all banks initialised
// BEHAVIOUR
//  - Reset (rst_i high at clk edge): gnt_o=0, r_valid_o=0, r_id_o=0, init_done_o=0, FSM->INIT (InitOnReset=1) or READY (0); r_data_o don't-care.
//  - FSM (shared, all banks in lockstep): INIT -> READY. INIT: counter 0..BankSize-1, each cycle writes 0 with be all-ones to word cnt in every bank; leaves INIT after cnt==BankSize-1 write; init_done_o=1 from the next cycle. BankSize cycles total.
//  - INIT: gnt_o=0, req_i ignored (no response). READY: gnt_o[i]=1 combinationally, req_i dropped only by reset.
//  - Accepted transaction = req_i[i]&gnt_o[i]. Write: be-masked write; read: full word.
//  - Response: exactly L cycles after acceptance r_valid_o[i]=1 for one cycle, r_id_o[i]=id of that request; r_data_o valid for reads, 0 for writes when OutReg=1, don't-care otherwise.
//  - Back-to-back: one accepted request per bank per cycle, full throughput; valid/ID shift register depth L, no bubbles.
//  - Read-after-write same address in consecutive cycles returns new data (macro order); no forwarding logic.
//  - Reset mid-operation: in-flight responses discarded (valid pipe cleared), INIT restarts from word 0.
//  - Unused address bits ignored; addresses beyond BankSize wrap by truncation.
// CONFIGURATION
//  Macro TCDM_BANK_PARITY_EN:
//   defined: macros widened to DataWidth+DataWidth/8; one even-parity bit per byte, written only for enabled bytes; INIT writes parity 0.
//    On read response, per-byte parity checked; extra output r_err_o (NbBanks) high with r_valid_o on mismatch;
//    extra output err_cnt_o (16b) counts erroneous responses across all banks, saturates at 0xFFFF, reset 0.
//   undefined: no parity storage, no r_err_o / err_cnt_o ports, macro width DataWidth.
// STRUCTURE
//  Package tcdm_banks_pkg: init FSM state enum (INIT, READY), byte-parity function, latency localparam helper.
//  Sub-module tcdm_bank_ctrl: one bank (macro, INIT mux, valid/ID pipe, optional parity check); top holds FSM, counter, err counter, generate loop.
// TESTING
//  1 Reset, InitOnReset=1, BankSize=256: gnt_o=0 for 256 cycles, init_done_o=1 at cycle 257; read bank 3 word 0x40 -> r_data_o=0.
//  2 Write 0xDEADBEEF be=4'hF bank 0 addr 0x10, then write 0x000000AA be=4'h1, read -> 0xDEADBEAA after L cycles, r_id_o echoes id.
//  3 Streaming reads every cycle, IDs 0,1,0,1, L=3 (SramLatency=2, OutReg=1): r_valid_o continuous, IDs in order, 3-cycle offset.
//  4 Assert rst_i with 2 reads in flight: no r_valid_o after reset, gnt_o=0, INIT restarts at word 0.
//  5 Simultaneous requests on all NbBanks banks, distinct data: each bank returns only its own data, no cross-talk.
//  6 TCDM_BANK_PARITY_EN: force-flip one stored bit via hierarchical deposit, read -> r_err_o=1, err_cnt_o 0->1; clean read -> r_err_o=0.

Source files
------------

// File: rtl/tcdm_banks_pkg.sv
// rtl/tcdm_banks_pkg.sv - shared constants and helpers for the TCDM bank array
// Init FSM encoding, response latency and byte parity used by the bank array and each bank.
package tcdm_banks_pkg;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int resp_latency(input int sram_lat, input int out_reg);
    return sram_lat + out_reg;
  endfunction

  // Even parity: the stored bit makes the byte plus parity bit XOR to zero.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tcdm_bank_ctrl.sv
// rtl/tcdm_bank_ctrl.sv - one TCDM bank: SRAM model, init write mux, valid/ID response pipe
// Optional per-byte parity storage and read check under TCDM_BANK_PARITY_EN.
module tcdm_bank_ctrl
  import tcdm_banks_pkg::*;
#(
  parameter int BankSize    = 256,
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 32,
  parameter int IdWidth     = 1,
  parameter int SramLatency = 1,
  parameter int OutReg      = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         test_mode_i,
  input  logic                         init_i,
  input  logic [$clog2(BankSize)-1:0]  init_addr_i,
  input  logic                         req_i,
  input  logic                         wen_i,
  input  logic [AddrWidth-1:0]         add_i,
  input  logic [DataWidth-1:0]         data_i,
  input  logic [DataWidth/8-1:0]       be_i,
  input  logic [IdWidth-1:0]           id_i,
`ifdef TCDM_BANK_PARITY_EN
  output logic                         r_err_o,
`endif
  output logic [DataWidth-1:0]         r_data_o,
  output logic                         r_valid_o,
  output logic [IdWidth-1:0]           r_id_o
);

  localparam int IW = $clog2(BankSize);
  localparam int BW = DataWidth / 8;
  localparam int L  = resp_latency(SramLatency, OutReg);
`ifdef TCDM_BANK_PARITY_EN
  localparam int MW = DataWidth + BW;
`else
  localparam int MW = DataWidth;
`endif

  logic [MW-1:0]  mem_q [BankSize];
  logic [MW-1:0]  rd_q;
  logic [MW-1:0]  wdata, wmask;
  logic [IW-1:0]  idx;
  logic           we, re, acc;

  always_comb begin
    idx   = init_i ? init_addr_i : add_i[IW+1:2];
    acc   = req_i & ~init_i;
    we    = init_i | (acc & ~wen_i);
    re    = acc & wen_i;
    wdata = '0;
    wmask = '0;
    if (init_i) begin
      wmask = '1;
    end else begin
      for (int b = 0; b < BW; b++) begin
        wdata[b*8 +: 8] = data_i[b*8 +: 8];
        wmask[b*8 +: 8] = {8{be_i[b]}};
`ifdef TCDM_BANK_PARITY_EN
        wdata[DataWidth+b] = byte_parity(data_i[b*8 +: 8]);
        wmask[DataWidth+b] = be_i[b];
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[idx] <= (mem_q[idx] & ~wmask) | (wdata & wmask);
    if (re) rd_q <= mem_q[idx];
  end

  // Valid, ID and read-flag travel together; depth equals the total latency.
  logic [L-1:0]              vld_q, isrd_q;
  logic [L-1:0][IdWidth-1:0] id_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      isrd_q <= '0;
      id_q   <= '0;
    end else begin
      vld_q[0]  <= acc;
      isrd_q[0] <= re;
      id_q[0]   <= id_i;
      for (int i = 1; i < L; i++) begin
        vld_q[i]  <= vld_q[i-1];
        isrd_q[i] <= isrd_q[i-1];
        id_q[i]   <= id_q[i-1];
      end
    end
  end

  logic [MW-1:0] sram_dat, fin_dat;

  if (SramLatency == 2) begin : g_lat2
    logic [MW-1:0] rd2_q;
    always_ff @(posedge clk_i) rd2_q <= rd_q;
    assign sram_dat = rd2_q;
  end else begin : g_lat1
    assign sram_dat = rd_q;
  end

  // The output stage zeroes write responses so the bus never sees stale read data.
  if (OutReg == 1) begin : g_oreg
    logic [MW-1:0] out_q;
    always_ff @(posedge clk_i) out_q <= isrd_q[SramLatency-1] ? sram_dat : '0;
    assign fin_dat = out_q;
  end else begin : g_noreg
    assign fin_dat = sram_dat;
  end

  assign r_data_o  = fin_dat[DataWidth-1:0];
  assign r_valid_o = vld_q[L-1];
  assign r_id_o    = id_q[L-1];

`ifdef TCDM_BANK_PARITY_EN
  logic [BW-1:0] par_err;
  always_comb begin
    par_err = '0;
    for (int b = 0; b < BW; b++) par_err[b] = byte_parity(fin_dat[b*8 +: 8]) ^ fin_dat[DataWidth+b];
  end
  assign r_err_o = vld_q[L-1] & isrd_q[L-1] & (|par_err);
`endif

  logic unused_ok;
  assign unused_ok = ^{test_mode_i, add_i, isrd_q};

endmodule

// File: rtl/tcdm_banks_pipe_wrap.sv
// rtl/tcdm_banks_pipe_wrap.sv - TCDM bank array with init FSM and pipelined responses
// TCDM_BANK_PARITY_EN adds per-byte parity, r_err_o and the saturating err_cnt_o.
module tcdm_banks_pipe_wrap
  import tcdm_banks_pkg::*;
#(
  parameter int BankSize    = 256,
  parameter int NbBanks     = 16,
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 32,
  parameter int IdWidth     = 1,
  parameter int SramLatency = 1,
  parameter int OutReg      = 0,
  parameter int InitOnReset = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                test_mode_i,
  input  logic [NbBanks-1:0]                  req_i,
  output logic [NbBanks-1:0]                  gnt_o,
  input  logic [NbBanks-1:0]                  wen_i,
  input  logic [NbBanks-1:0][AddrWidth-1:0]   add_i,
  input  logic [NbBanks-1:0][DataWidth-1:0]   data_i,
  input  logic [NbBanks-1:0][DataWidth/8-1:0] be_i,
  input  logic [NbBanks-1:0][IdWidth-1:0]     id_i,
  output logic [NbBanks-1:0][DataWidth-1:0]   r_data_o,
  output logic [NbBanks-1:0]                  r_valid_o,
  output logic [NbBanks-1:0][IdWidth-1:0]     r_id_o,
`ifdef TCDM_BANK_PARITY_EN
  output logic [NbBanks-1:0]                  r_err_o,
  output logic [15:0]                         err_cnt_o,
`endif
  output logic                                init_done_o
);

  localparam int IW = $clog2(BankSize);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          init_done_q;
  logic          init_act, gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IW'(1);
      if (cnt_q == IW'(BankSize - 1)) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= (InitOnReset != 0) ? ST_INIT : ST_READY;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  assign init_act    = (state_q == ST_INIT);
  assign gnt         = (state_q == ST_READY);
  assign gnt_o       = {NbBanks{gnt}};
  assign init_done_o = init_done_q;

  for (genvar g = 0; g < NbBanks; g++) begin : g_bank
    tcdm_bank_ctrl #(
      .BankSize    (BankSize),
      .DataWidth   (DataWidth),
      .AddrWidth   (AddrWidth),
      .IdWidth     (IdWidth),
      .SramLatency (SramLatency),
      .OutReg      (OutReg)
    ) u_bank (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .test_mode_i (test_mode_i),
      .init_i      (init_act),
      .init_addr_i (cnt_q),
      .req_i       (req_i[g] & gnt),
      .wen_i       (wen_i[g]),
      .add_i       (add_i[g]),
      .data_i      (data_i[g]),
      .be_i        (be_i[g]),
      .id_i        (id_i[g]),
`ifdef TCDM_BANK_PARITY_EN
      .r_err_o     (r_err_o[g]),
`endif
      .r_data_o    (r_data_o[g]),
      .r_valid_o   (r_valid_o[g]),
      .r_id_o      (r_id_o[g])
    );
  end

`ifdef TCDM_BANK_PARITY_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  always_comb begin
    err_sum = {1'b0, err_cnt_q};
    for (int b = 0; b < NbBanks; b++) err_sum = err_sum + 17'(r_err_o[b]);
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_banks_pipe_wrap.sv
// tb/tb_tcdm_banks_pipe_wrap.sv - scoreboard bench for tcdm_banks_pipe_wrap (L = 3 configuration)
// Parity scenario compiled only with TCDM_BANK_PARITY_EN.
module tb_tcdm_banks_pipe_wrap;

  localparam int BankSize = 256;
  localparam int NbBanks  = 16;
  localparam int DW       = 32;
  localparam int AW       = 32;
  localparam int IdW      = 1;
  localparam int BW       = DW / 8;
  localparam int IW       = 8;
  localparam int L        = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_i, test_mode_i;
  logic [NbBanks-1:0]            req_i, gnt_o, wen_i, r_valid_o;
  logic [NbBanks-1:0][AW-1:0]    add_i;
  logic [NbBanks-1:0][DW-1:0]    data_i, r_data_o;
  logic [NbBanks-1:0][BW-1:0]    be_i;
  logic [NbBanks-1:0][IdW-1:0]   id_i, r_id_o;
  logic                          init_done_o;
`ifdef TCDM_BANK_PARITY_EN
  logic [NbBanks-1:0]            r_err_o;
  logic [15:0]                   err_cnt_o;
`endif

  tcdm_banks_pipe_wrap #(
    .BankSize(BankSize), .NbBanks(NbBanks), .DataWidth(DW), .AddrWidth(AW), .IdWidth(IdW),
    .SramLatency(2), .OutReg(1), .InitOnReset(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .test_mode_i(test_mode_i),
    .req_i(req_i), .gnt_o(gnt_o), .wen_i(wen_i), .add_i(add_i), .data_i(data_i),
    .be_i(be_i), .id_i(id_i), .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_id_o(r_id_o),
`ifdef TCDM_BANK_PARITY_EN
    .r_err_o(r_err_o), .err_cnt_o(err_cnt_o),
`endif
    .init_done_o(init_done_o)
  );

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t         sbq   [NbBanks][$];
  logic [DW-1:0] model [NbBanks][BankSize];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic clear_state();
    for (int b = 0; b < NbBanks; b++) begin
      sbq[b].delete();
      for (int w = 0; w < BankSize; w++) model[b][w] = '0;
    end
  endtask

  // Drive one request on bank b for the coming edge and record its expected response.
  task automatic drive_req(input int b, input logic rd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [BW-1:0] be, input logic [IdW-1:0] id);
    int   w;
    exp_t e;
    w = int'(addr[IW+1:2]);
    req_i[b] = 1'b1; wen_i[b] = rd; add_i[b] = addr; data_i[b] = data; be_i[b] = be; id_i[b] = id;
    e.id = id;
    if (rd) e.data = model[b][w];
    else begin
      for (int k = 0; k < BW; k++) if (be[k]) model[b][w][k*8 +: 8] = data[k*8 +: 8];
      e.data = '0;
    end
    sbq[b].push_back(e);
  endtask

  task automatic test_reset();
    int bad_cycles;
    rst_i = 1'b1; req_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt_o !== '0) begin n_bad++; $display("FAIL rst_gnt got %h want 0", gnt_o); end
    n_cmp++; if (r_valid_o !== '0) begin n_bad++; $display("FAIL rst_valid got %h want 0", r_valid_o); end
    n_cmp++; if (r_id_o !== '0) begin n_bad++; $display("FAIL rst_id got %h want 0", r_id_o); end
    n_cmp++; if (init_done_o !== 1'b0) begin n_bad++; $display("FAIL rst_init_done got %b want 0", init_done_o); end
`ifdef TCDM_BANK_PARITY_EN
    n_cmp++; if (err_cnt_o !== 16'h0) begin n_bad++; $display("FAIL rst_err_cnt got %h want 0", err_cnt_o); end
`endif
    clear_state();
    rst_i = 1'b0;
    bad_cycles = 0;
    for (int i = 0; i < BankSize; i++) begin
      if (gnt_o !== '0 || init_done_o !== 1'b0) bad_cycles++;
      @(negedge clk);
    end
    n_cmp++; if (bad_cycles != 0) begin n_bad++; $display("FAIL init_hold got %0d granting cycles want 0", bad_cycles); end
    n_cmp++; if (gnt_o !== '1) begin n_bad++; $display("FAIL init_end_gnt got %h want ffff", gnt_o); end
    n_cmp++; if (init_done_o !== 1'b1) begin n_bad++; $display("FAIL init_done got %b want 1", init_done_o); end
  endtask

  task automatic test_init_read();
    for (int k = 0; k < 5; k++) begin
      req_i = '0;
      if (k == 0) drive_req(3, 1'b1, 32'h0000_0100, 32'h0, 4'hF, 1'b1);
      if (k == 3) begin
        n_cmp++;
        if (r_valid_o[3] !== 1'b1 || r_data_o[3] !== 32'h0)
          begin n_bad++; $display("FAIL init_read got v=%b d=%h want v=1 d=0", r_valid_o[3], r_data_o[3]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_merge();
    for (int k = 0; k < 7; k++) begin
      req_i = '0;
      if (k == 0) drive_req(0, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0);
      if (k == 1) drive_req(0, 1'b0, 32'h0000_0010, 32'h000000AA, 4'h1, 1'b0);
      if (k == 2) drive_req(0, 1'b1, 32'h0000_0010, 32'h0, 4'hF, 1'b1);
      if (k == 3) begin
        n_cmp++;
        if (r_valid_o[0] !== 1'b1 || r_data_o[0] !== 32'h0)
          begin n_bad++; $display("FAIL wr_rsp_zero got v=%b d=%h want v=1 d=0", r_valid_o[0], r_data_o[0]); end
      end
      if (k == 5) begin
        n_cmp++;
        if (r_valid_o[0] !== 1'b1 || r_data_o[0] !== 32'hDEADBEAA || r_id_o[0] !== 1'b1)
          begin n_bad++; $display("FAIL be_merge got v=%b d=%h id=%b want v=1 d=deadbeaa id=1", r_valid_o[0], r_data_o[0], r_id_o[0]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 9; k++) begin
      req_i = '0;
      if (k < 4) drive_req(2, 1'b1, AW'(k * 4), 32'h0, 4'hF, IdW'(k & 1));
      n_cmp++;
      if (r_valid_o[2] !== ((k >= 3) && (k <= 6)))
        begin n_bad++; $display("FAIL stream_valid k=%0d got %b want %b", k, r_valid_o[2], (k >= 3) && (k <= 6)); end
      if (k >= 3 && k <= 6) begin
        n_cmp++;
        if (r_id_o[2] !== IdW'((k - 3) & 1))
          begin n_bad++; $display("FAIL stream_id k=%0d got %b want %0d", k, r_id_o[2], (k - 3) & 1); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all_banks();
    logic [DW-1:0] want;
    for (int k = 0; k < 6; k++) begin
      req_i = '0;
      for (int b = 0; b < NbBanks; b++) begin
        want = 32'hB000_0000 | (DW'(b) << 8) | DW'(b);
        if (k == 0) drive_req(b, 1'b0, 32'h0000_0020, want, 4'hF, 1'b0);
        if (k == 1) drive_req(b, 1'b1, 32'h0000_0020, 32'h0, 4'hF, 1'b1);
        if (k == 4) begin
          n_cmp++;
          if (r_valid_o[b] !== 1'b1 || r_data_o[b] !== want)
            begin n_bad++; $display("FAIL bank_iso b=%0d got %h want %h", b, r_data_o[b], want); end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int       w;
    logic [AW-1:0] a;
    for (int c = 0; c < 300; c++) begin
      req_i = '0;
      for (int b = 0; b < NbBanks; b++) begin
        if ($urandom_range(0, 3) != 0) begin
          w = $urandom_range(0, 7);
          if (w >= 4) w = 248 + w;
          a = ($urandom() & ~32'h0000_03FC) | AW'(w << 2);
          drive_req(b, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
      end
      @(negedge clk);
    end
    req_i = '0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      req_i = '0;
      if (k == 0) drive_req(1, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'hF, 1'b0);
      if (k >= 1) drive_req(1, 1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      @(negedge clk);
    end
    req_i = '0;
    test_reset();
    test_init_read();
    for (int k = 0; k < 5; k++) begin
      req_i = '0;
      if (k == 0) drive_req(1, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0);
      if (k == 3) begin
        n_cmp++;
        if (r_valid_o[1] !== 1'b1 || r_data_o[1] !== 32'h0)
          begin n_bad++; $display("FAIL reinit_word0 got v=%b d=%h want v=1 d=0", r_valid_o[1], r_data_o[1]); end
      end
      @(negedge clk);
    end
  endtask

`ifdef TCDM_BANK_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < 12; k++) begin
      req_i = '0;
      if (k == 0) drive_req(5, 1'b0, 32'h0000_00C0, 32'h1234_5678, 4'hF, 1'b0);
      if (k == 1) drive_req(5, 1'b1, 32'h0000_00C0, 32'h0, 4'hF, 1'b0);
      if (k == 4) begin
        n_cmp++; if (r_err_o[5] !== 1'b0) begin n_bad++; $display("FAIL par_clean got %b want 0", r_err_o[5]); end
        dut.g_bank[5].u_bank.mem_q[8'h30][3] = ~dut.g_bank[5].u_bank.mem_q[8'h30][3];
        model[5][8'h30][3] = ~model[5][8'h30][3];
      end
      if (k == 5) drive_req(5, 1'b1, 32'h0000_00C0, 32'h0, 4'hF, 1'b1);
      if (k == 8) begin
        n_cmp++; if (r_err_o[5] !== 1'b1) begin n_bad++; $display("FAIL par_err got %b want 1", r_err_o[5]); end
        n_cmp++; if (err_cnt_o !== 16'd0) begin n_bad++; $display("FAIL err_cnt_pre got %0d want 0", err_cnt_o); end
      end
      if (k == 9) begin
        n_cmp++; if (err_cnt_o !== 16'd1) begin n_bad++; $display("FAIL err_cnt_post got %0d want 1", err_cnt_o); end
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_drain();
    int left;
    req_i = '0;
    repeat (L + 2) @(negedge clk);
    left = 0;
    for (int b = 0; b < NbBanks; b++) left += sbq[b].size();
    n_cmp++; if (left != 0) begin n_bad++; $display("FAIL drain got %0d outstanding want 0", left); end
  endtask

  initial begin
    rst_i = 1'b1; test_mode_i = 1'b0; req_i = '0; wen_i = '1;
    add_i = '0; data_i = '0; be_i = '0; id_i = '0;
    clear_state();
    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst_i) begin
            for (int b = 0; b < NbBanks; b++) begin
              if (r_valid_o[b]) begin
                n_cmp++;
                if (sbq[b].size() == 0) begin
                  n_bad++; $display("FAIL sb_extra b=%0d got unexpected response want none", b);
                end else begin
                  e = sbq[b].pop_front();
                  if (r_id_o[b] !== e.id || r_data_o[b] !== e.data) begin
                    n_bad++;
                    $display("FAIL sb_rsp b=%0d got id=%b d=%h want id=%b d=%h", b, r_id_o[b], r_data_o[b], e.id, e.data);
                  end
                end
              end
            end
          end
        end
      end
    join_none
    test_reset();
    test_init_read();
    test_write_merge();
    test_stream();
    test_all_banks();
    test_back_to_back();
    test_drain();
`ifdef TCDM_BANK_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
